// File: rtl/riscv_ctrl_pkg.sv
// Shared opcode, state and mux-select constants for the multicycle RV32I control path.
// alu_decoder imports the ALUOP_* encodings from here as well.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } ctrl_state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_RESULT = 1'b1;

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational state-to-control decoder for the multicycle FSM.
// Moore outputs, except the FETCH strobes which follow mem_ready; reset masks all strobes.
module ctrl_out_decode
    import riscv_ctrl_pkg::*;
(
    input  ctrl_state_t state,
    input  logic        reset,
    input  logic        mem_ready,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCUpdate,
    output logic        Branch,
    output logic        RegWrite,
    output logic        MemWrite
);

    ctrl_state_t eff_state_s;
    logic        ir_write_s;
    logic        pc_update_s;
    logic        branch_s;
    logic        reg_write_s;
    logic        mem_write_s;

    // Decode selects and raw strobes; during reset the selects already show FETCH values.
    always_comb begin
        eff_state_s = reset ? FETCH : state;
        ALUOp       = ALUOP_ADD;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RD2;
        ResultSrc   = RES_ALUOUT;
        AdrSrc      = ADR_PC;
        ir_write_s  = 1'b0;
        pc_update_s = 1'b0;
        branch_s    = 1'b0;
        reg_write_s = 1'b0;
        mem_write_s = 1'b0;
        case (eff_state_s)
            FETCH: begin
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALURESULT;
                ir_write_s  = mem_ready;
                pc_update_s = mem_ready;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD: begin
                AdrSrc = ADR_RESULT;
            end
            MEMWB: begin
                ResultSrc   = RES_DATA;
                reg_write_s = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc      = ADR_RESULT;
                mem_write_s = 1'b1;
            end
            EXECR: begin
                ALUSrcA = SRCA_RD1;
                ALUOp   = ALUOP_FUNCT;
            end
            EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_write_s = 1'b1;
            end
            BEQ: begin
                ALUSrcA  = SRCA_RD1;
                ALUOp    = ALUOP_SUB;
                branch_s = 1'b1;
            end
            JAL: begin
                ALUSrcA     = SRCA_OLDPC;
                ALUSrcB     = SRCB_FOUR;
                pc_update_s = 1'b1;
            end
            // TRAP and unused encodings drive nothing.
            default: begin
                ALUOp = ALUOP_ADD;
            end
        endcase
    end

    assign IRWrite  = ir_write_s  & ~reset;
    assign PCUpdate = pc_update_s & ~reset;
    assign Branch   = branch_s    & ~reset;
    assign RegWrite = reg_write_s & ~reset;
    assign MemWrite = mem_write_s & ~reset;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I main control FSM with mem_ready handshake.
// Optional macro ILLEGAL_OP_TRAP_EN: unknown opcodes enter a sticky TRAP state.
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       illegal
);

    ctrl_state_t state_r;
    ctrl_state_t next_s;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; mem_ready only matters in the three memory-facing states.
    always_comb begin
        next_s = FETCH;
        case (state_r)
            FETCH:    next_s = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE:  next_s = MEMADR;
                    OP_RTYPE:  next_s = EXECR;
                    OP_ITYPE:  next_s = EXECI;
                    OP_BRANCH: next_s = BEQ;
                    OP_JAL:    next_s = JAL;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:   next_s = TRAP;
`else
                    default:   next_s = FETCH;
`endif
                endcase
            end
            MEMADR:   next_s = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  next_s = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    next_s = FETCH;
            MEMWRITE: next_s = mem_ready ? FETCH : MEMWRITE;
            EXECR:    next_s = ALUWB;
            EXECI:    next_s = ALUWB;
            ALUWB:    next_s = FETCH;
            BEQ:      next_s = FETCH;
            JAL:      next_s = ALUWB;
`ifdef ILLEGAL_OP_TRAP_EN
            TRAP:     next_s = TRAP;
`endif
            default:  next_s = FETCH;
        endcase
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_r;

    // Sticky illegal flag, set on the DECODE->TRAP transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_r <= 1'b0;
        end else if ((state_r == DECODE) && (next_s == TRAP)) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign illegal = illegal_r;
`else
    assign illegal = 1'b0;
`endif

    ctrl_out_decode u_out_decode (
        .state     (state_r),
        .reset     (reset),
        .mem_ready (mem_ready),
        .ALUOp     (ALUOp),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .AdrSrc    (AdrSrc),
        .IRWrite   (IRWrite),
        .PCUpdate  (PCUpdate),
        .Branch    (Branch),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite)
    );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle output vectors checked against hand-built constants.
// Honours ILLEGAL_OP_TRAP_EN for the unknown-opcode expectations.
module tb_multicycle_ctrl_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       mem_ready;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCUpdate;
    logic       Branch;
    logic       RegWrite;
    logic       MemWrite;
    logic       illegal;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, illegal}
    localparam logic [14:0] V_FETCH   = 15'b00_00_10_10_0_1_1_0_0_0_0;
    localparam logic [14:0] V_FSTALL  = 15'b00_00_10_10_0_0_0_0_0_0_0;
    localparam logic [14:0] V_DECODE  = 15'b00_01_01_00_0_0_0_0_0_0_0;
    localparam logic [14:0] V_MEMADR  = 15'b00_10_01_00_0_0_0_0_0_0_0;
    localparam logic [14:0] V_MEMREAD = 15'b00_00_00_00_1_0_0_0_0_0_0;
    localparam logic [14:0] V_MEMWB   = 15'b00_00_00_01_0_0_0_0_1_0_0;
    localparam logic [14:0] V_MEMWR   = 15'b00_00_00_00_1_0_0_0_0_1_0;
    localparam logic [14:0] V_EXECR   = 15'b10_10_00_00_0_0_0_0_0_0_0;
    localparam logic [14:0] V_EXECI   = 15'b10_10_01_00_0_0_0_0_0_0_0;
    localparam logic [14:0] V_ALUWB   = 15'b00_00_00_00_0_0_0_0_1_0_0;
    localparam logic [14:0] V_BEQ     = 15'b01_10_00_00_0_0_0_1_0_0_0;
    localparam logic [14:0] V_JAL     = 15'b00_01_10_00_0_0_1_0_0_0_0;
    localparam logic [14:0] V_TRAP    = 15'b00_00_00_00_0_0_0_0_0_0_1;
    localparam logic [14:0] V_RSTILL  = 15'b00_00_10_10_0_0_0_0_0_0_1;

    logic [14:0] obs_s;
    assign obs_s = {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
                    IRWrite, PCUpdate, Branch, RegWrite, MemWrite, illegal};

    multicycle_ctrl_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .mem_ready (mem_ready),
        .ALUOp     (ALUOp),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .AdrSrc    (AdrSrc),
        .IRWrite   (IRWrite),
        .PCUpdate  (PCUpdate),
        .Branch    (Branch),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [14:0] exp);
        total_cnt++;
        assert (obs_s === exp) else begin
            bad_cnt++;
            $error("FAIL %s observed=%b expected=%b", tag, obs_s, exp);
        end
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        op        = 7'b0000000;

        // reset for two cycles: strobes masked, FETCH selects
        #1;
        chk("reset_pre", V_FSTALL);
        adv();
        chk("reset_c1", V_FSTALL);
        adv();
        chk("reset_c2", V_FSTALL);
        reset = 1'b0;
        #1;
        chk("post_reset_fetch", V_FETCH);

        // lw, mem_ready=1: 5 cycles
        op = 7'b0000011;
        adv(); chk("lw_decode", V_DECODE);
        adv(); chk("lw_memadr", V_MEMADR);
        adv(); chk("lw_memread", V_MEMREAD);
        adv(); chk("lw_memwb", V_MEMWB);
        adv(); chk("lw_fetch", V_FETCH);

        // fetch stall
        mem_ready = 1'b0;
        #1; chk("fetch_stall0", V_FSTALL);
        adv(); chk("fetch_stall1", V_FSTALL);
        mem_ready = 1'b1;
        #1; chk("fetch_release", V_FETCH);

        // sw with three stalled MEMWRITE cycles
        op = 7'b0100011;
        adv(); chk("sw_decode", V_DECODE);
        adv(); mem_ready = 1'b0; #1; chk("sw_memadr", V_MEMADR);
        adv(); chk("sw_memwr1", V_MEMWR);
        adv(); chk("sw_memwr2", V_MEMWR);
        adv(); chk("sw_memwr3", V_MEMWR);
        mem_ready = 1'b1;
        #1; chk("sw_memwr4", V_MEMWR);
        adv(); chk("sw_fetch", V_FETCH);

        // R-type
        op = 7'b0110011;
        adv(); chk("r_decode", V_DECODE);
        adv(); chk("r_execr", V_EXECR);
        adv(); chk("r_aluwb", V_ALUWB);
        adv(); chk("r_fetch", V_FETCH);

        // beq
        op = 7'b1100011;
        adv(); chk("beq_decode", V_DECODE);
        adv(); chk("beq_beq", V_BEQ);
        adv(); chk("beq_fetch", V_FETCH);

        // I-type
        op = 7'b0010011;
        adv(); chk("i_decode", V_DECODE);
        adv(); chk("i_execi", V_EXECI);
        adv(); chk("i_aluwb", V_ALUWB);
        adv(); chk("i_fetch", V_FETCH);

        // jal
        op = 7'b1101111;
        adv(); chk("jal_decode", V_DECODE);
        adv(); chk("jal_jal", V_JAL);
        adv(); chk("jal_aluwb", V_ALUWB);
        adv(); chk("jal_fetch", V_FETCH);

        // unknown opcode
        op = 7'b1111111;
        adv(); chk("ill_decode", V_DECODE);
`ifdef ILLEGAL_OP_TRAP_EN
        adv(); chk("ill_trap1", V_TRAP);
        mem_ready = 1'b0;
        adv(); chk("ill_trap2", V_TRAP);
        mem_ready = 1'b1;
        adv(); chk("ill_trap3", V_TRAP);
        reset = 1'b1;
        #1; chk("ill_reset", V_RSTILL);
        adv(); chk("ill_reset_clr", V_FSTALL);
        reset = 1'b0;
        #1; chk("ill_after_reset", V_FETCH);
`else
        adv(); chk("ill_nop_fetch", V_FETCH);
`endif

        // reset in the middle of a MEMREAD stall
        op = 7'b0000011;
        adv(); chk("rs_lw_decode", V_DECODE);
        adv(); mem_ready = 1'b0; #1; chk("rs_lw_memadr", V_MEMADR);
        adv(); chk("rs_memread1", V_MEMREAD);
        adv(); chk("rs_memread2", V_MEMREAD);
        reset = 1'b1;
        #1; chk("rs_memread_rst", V_FSTALL);
        adv(); reset = 1'b0; mem_ready = 1'b1;
        #1; chk("rs_memread_fetch", V_FETCH);

        // reset in the middle of a MEMWRITE stall: MemWrite must drop immediately
        op = 7'b0100011;
        adv(); chk("rs_sw_decode", V_DECODE);
        adv(); mem_ready = 1'b0; #1; chk("rs_sw_memadr", V_MEMADR);
        adv(); chk("rs_memwr1", V_MEMWR);
        reset = 1'b1;
        #1; chk("rs_memwr_rst", V_FSTALL);
        adv(); reset = 1'b0; mem_ready = 1'b1;
        #1; chk("rs_memwr_fetch", V_FETCH);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
